// File: rtl/cmd_exec_pkg.sv
// Shared types for the command executor: opcodes, FSM states and a small
// constant helper used to size the select port.
package cmd_exec_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_SIGNAL    = 3'd1,
        OP_WAIT_SIG  = 3'd2,
        OP_DELAY     = 3'd3,
        OP_FLAG_SET  = 3'd4,
        OP_FLAG_CLR  = 3'd5,
        OP_WAIT_FLAG = 3'd6,
        OP_END       = 3'd7
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_WAIT_SIG,
        ST_WAIT_FLAG
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cmd_exec_counter.sv
// Down-counter shared by DELAY and the wait timeout: load, decrement, zero flag.
module cmd_exec_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cmd_executor.sv
// Command executor: accepts one command per idle cycle, drives signal lines and
// flags, and sequences delays and bounded waits on sampled lines or flags.
module cmd_executor
    import cmd_exec_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NUM_SIGNALS  = 8,
    parameter int NUM_FLAGS    = 16,
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                cmd_valid,
    output logic                                                cmd_ready,
    input  logic [2:0]                                          cmd_op,
    input  logic [$clog2(max_int(NUM_SIGNALS, NUM_FLAGS))-1:0]  cmd_sel,
    input  logic [DATA_W-1:0]                                   cmd_arg,
    input  logic [NUM_SIGNALS-1:0]                              sig_in,
    output logic [NUM_SIGNALS-1:0]                              sig_out,
    output logic [NUM_FLAGS-1:0]                                flags,
    output logic                                                vector_done,
    output logic [DATA_W-1:0]                                   vector_id,
    output logic                                                error
);

    localparam int SEL_W  = $clog2(max_int(NUM_SIGNALS, NUM_FLAGS));
    localparam int SIG_IW = $clog2(NUM_SIGNALS);
    localparam int FLG_IW = $clog2(NUM_FLAGS);
    localparam logic [SEL_W:0]    SIG_LIM  = (SEL_W+1)'(NUM_SIGNALS);
    localparam logic [SEL_W:0]    FLG_LIM  = (SEL_W+1)'(NUM_FLAGS);
    localparam logic [DATA_W-1:0] TMO_LOAD = DATA_W'(WAIT_TIMEOUT - 1);

    state_t                   state_q, state_d;
    logic [NUM_SIGNALS-1:0]   sig_out_q, sig_out_d;
    logic [NUM_FLAGS-1:0]     flags_q, flags_d;
    logic                     vector_done_q, vector_done_d;
    logic [DATA_W-1:0]        vector_id_q, vector_id_d;
    logic                     error_q, error_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic                     bit_q, bit_d;
    logic                     rdy_q, rdy_d;

    logic                     cnt_load, cnt_dec, cnt_zero;
    logic [DATA_W-1:0]        cnt_val;
    logic                     accept, sig_ok, flg_ok, wait_hit;
    logic [SIG_IW-1:0]        sig_idx;
    logic [FLG_IW-1:0]        flg_idx;

    cmd_exec_counter #(.W(DATA_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // rdy_q holds ready low through reset and for the release cycle, so ready
    // rises on the first edge after rst drops.
    assign cmd_ready = rdy_q && (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign sig_ok    = {1'b0, cmd_sel} < SIG_LIM;
    assign flg_ok    = {1'b0, cmd_sel} < FLG_LIM;
    assign sig_idx   = cmd_sel[SIG_IW-1:0];
    assign flg_idx   = cmd_sel[FLG_IW-1:0];
    assign wait_hit  = (state_q == ST_WAIT_SIG) ? (sig_in[sel_q[SIG_IW-1:0]] == bit_q)
                                                : (flags_q[sel_q[FLG_IW-1:0]] == bit_q);

    always_comb begin
        state_d       = state_q;
        sig_out_d     = sig_out_q;
        flags_d       = flags_q;
        vector_done_d = 1'b0;
        vector_id_d   = vector_id_q;
        error_d       = error_q;
        sel_d         = sel_q;
        bit_d         = bit_q;
        rdy_d         = 1'b1;
        cnt_load      = 1'b0;
        cnt_val       = '0;
        cnt_dec       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op_t'(cmd_op))
                        OP_SIGNAL: begin
                            if (sig_ok) sig_out_d[sig_idx] = cmd_arg[0];
                            else        error_d = 1'b1;
                        end
                        OP_WAIT_SIG, OP_WAIT_FLAG: begin
                            if ((cmd_op_t'(cmd_op) == OP_WAIT_SIG) ? sig_ok : flg_ok) begin
                                state_d  = (cmd_op_t'(cmd_op) == OP_WAIT_SIG) ? ST_WAIT_SIG
                                                                              : ST_WAIT_FLAG;
                                sel_d    = cmd_sel;
                                bit_d    = cmd_arg[0];
                                cnt_load = 1'b1;
                                cnt_val  = TMO_LOAD;
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                        OP_DELAY: begin
                            // Load N-1 so the counter never wraps, even for all-ones N.
                            if (cmd_arg != '0) begin
                                state_d  = ST_DELAY;
                                cnt_load = 1'b1;
                                cnt_val  = cmd_arg - DATA_W'(1);
                            end
                        end
                        OP_FLAG_SET, OP_FLAG_CLR: begin
                            if (flg_ok) flags_d[flg_idx] = (cmd_op_t'(cmd_op) == OP_FLAG_SET);
                            else        error_d = 1'b1;
                        end
                        OP_END: begin
                            vector_done_d = 1'b1;
                            vector_id_d   = cmd_arg;
                        end
                        default: ;
                    endcase
                end
            end
            ST_DELAY: begin
                if (cnt_zero) state_d = ST_IDLE;
                else          cnt_dec = 1'b1;
            end
            ST_WAIT_SIG, ST_WAIT_FLAG: begin
                if (wait_hit) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sig_out_q     <= '0;
            flags_q       <= '0;
            vector_done_q <= 1'b0;
            vector_id_q   <= '0;
            error_q       <= 1'b0;
            sel_q         <= '0;
            bit_q         <= 1'b0;
            rdy_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sig_out_q     <= sig_out_d;
            flags_q       <= flags_d;
            vector_done_q <= vector_done_d;
            vector_id_q   <= vector_id_d;
            error_q       <= error_d;
            sel_q         <= sel_d;
            bit_q         <= bit_d;
            rdy_q         <= rdy_d;
        end
    end

    assign sig_out     = sig_out_q;
    assign flags       = flags_q;
    assign vector_done = vector_done_q;
    assign vector_id   = vector_id_q;
    assign error       = error_q;

endmodule

// File: tb/tb_cmd_executor.sv
// Bench for cmd_executor: directed vector table, multi-cycle corner sequences
// and random commands scored against a transaction-level model.
module tb_cmd_executor;

    localparam int DW  = 8;
    localparam int NS  = 32;
    localparam int NF  = 16;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [4:0]    cmd_sel = '0;
    logic [DW-1:0] cmd_arg = '0;
    logic [NS-1:0] sig_in = '0;
    logic [NS-1:0] sig_out;
    logic [NF-1:0] flags;
    logic          vector_done;
    logic [DW-1:0] vector_id;
    logic          error;

    int vectors = 0;
    int miscompares = 0;

    logic [NS-1:0] m_sig;
    logic [NF-1:0] m_flags;
    logic [DW-1:0] m_vid;
    logic          m_err;

    cmd_executor #(.DATA_W(DW), .NUM_SIGNALS(NS), .NUM_FLAGS(NF), .WAIT_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_arg(cmd_arg), .sig_in(sig_in),
        .sig_out(sig_out), .flags(flags), .vector_done(vector_done),
        .vector_id(vector_id), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    op;
        logic [4:0]    sel;
        logic [DW-1:0] arg;
        logic [NS-1:0] sig;
        logic [NF-1:0] flg;
        logic          done;
        logic [DW-1:0] vid;
        logic          err;
        int            busy;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; sig_in = '0;
        @(posedge clk); #1;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_sig_out", sig_out, 0);
        chk("rst_flags", flags, 0);
        chk("rst_done", vector_done, 0);
        chk("rst_vid", vector_id, 0);
        chk("rst_error", error, 0);
        rst = 1'b0; #1;
        chk("ready_before_edge", cmd_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_edge", cmd_ready, 1);
        m_sig = '0; m_flags = '0; m_vid = '0; m_err = 1'b0;
    endtask

    // Issues one command and checks its visible effect plus ready-low duration.
    task automatic run_cmd(input logic [2:0] op, input logic [4:0] sel, input logic [DW-1:0] arg,
                           input logic [NS-1:0] e_sig, input logic [NF-1:0] e_flg,
                           input logic e_done, input logic [DW-1:0] e_vid,
                           input logic e_err, input int e_busy);
        int n;
        chk("ready_pre", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_arg = arg;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("sig_out", sig_out, e_sig);
        chk("flags", flags, e_flg);
        chk("vector_done", vector_done, e_done);
        chk("vector_id", vector_id, e_vid);
        n = 0;
        while (!cmd_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_cycles", n, e_busy);
        chk("error", error, e_err);
    endtask

    // Reference: effect of a command from the rules alone; sig_in is held
    // constant across a random command, so a wait either hits at once or times out.
    task automatic model(input logic [2:0] op, input logic [4:0] sel, input logic [DW-1:0] arg,
                         output int busy, output logic done);
        busy = 0; done = 1'b0;
        case (op)
            3'd1: m_sig[sel] = arg[0];
            3'd2: if (sig_in[sel] == arg[0]) busy = 1; else begin busy = TMO; m_err = 1'b1; end
            3'd3: busy = int'(arg);
            3'd4: if (sel < NF) m_flags[sel[3:0]] = 1'b1; else m_err = 1'b1;
            3'd5: if (sel < NF) m_flags[sel[3:0]] = 1'b0; else m_err = 1'b1;
            3'd6: if (sel >= NF) m_err = 1'b1;
                  else if (m_flags[sel[3:0]] == arg[0]) busy = 1;
                  else begin busy = TMO; m_err = 1'b1; end
            3'd7: begin done = 1'b1; m_vid = arg; end
            default: ;
        endcase
    endtask

    initial begin
        int   busy;
        logic done;
        logic [2:0] op;
        logic [4:0] sel;
        logic [DW-1:0] arg;

        //          op    sel    arg     sig_out        flags    done vid   err busy
        tbl[0]  = '{3'd1, 5'd3,  8'd1,   32'h0000_0008, 16'h0,   0, 8'd0, 0, 0};
        tbl[1]  = '{3'd1, 5'd3,  8'd0,   32'h0,         16'h0,   0, 8'd0, 0, 0};
        tbl[2]  = '{3'd0, 5'd7,  8'hff,  32'h0,         16'h0,   0, 8'd0, 0, 0};
        tbl[3]  = '{3'd4, 5'd4,  8'd0,   32'h0,         16'h10,  0, 8'd0, 0, 0};
        tbl[4]  = '{3'd5, 5'd4,  8'd0,   32'h0,         16'h0,   0, 8'd0, 0, 0};
        tbl[5]  = '{3'd3, 5'd0,  8'd5,   32'h0,         16'h0,   0, 8'd0, 0, 5};
        tbl[6]  = '{3'd3, 5'd0,  8'd0,   32'h0,         16'h0,   0, 8'd0, 0, 0};
        tbl[7]  = '{3'd7, 5'd0,  8'd7,   32'h0,         16'h0,   1, 8'd7, 0, 0};
        tbl[8]  = '{3'd1, 5'd31, 8'd1,   32'h8000_0000, 16'h0,   0, 8'd7, 0, 0};
        tbl[9]  = '{3'd4, 5'd15, 8'd0,   32'h8000_0000, 16'h8000, 0, 8'd7, 0, 0};
        tbl[10] = '{3'd6, 5'd15, 8'd1,   32'h8000_0000, 16'h8000, 0, 8'd7, 0, 1};
        tbl[11] = '{3'd2, 5'd0,  8'd0,   32'h8000_0000, 16'h8000, 0, 8'd7, 0, 1};
        tbl[12] = '{3'd4, 5'd20, 8'd0,   32'h8000_0000, 16'h8000, 0, 8'd7, 1, 0};
        tbl[13] = '{3'd7, 5'd0,  8'd9,   32'h8000_0000, 16'h8000, 1, 8'd9, 1, 0};
        tbl[14] = '{3'd1, 5'd31, 8'hfe,  32'h0,         16'h8000, 0, 8'd9, 1, 0};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            run_cmd(tbl[i].op, tbl[i].sel, tbl[i].arg, tbl[i].sig, tbl[i].flg,
                    tbl[i].done, tbl[i].vid, tbl[i].err, tbl[i].busy);
            if (tbl[i].done) begin
                @(posedge clk); #1;
                chk("done_single_pulse", vector_done, 0);
            end
        end

        // WAIT_SIG sel=2 arg=1, line rises 10 cycles after accept
        do_reset();
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_sel = 5'd2; cmd_arg = 8'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("wait_sig_holding", cmd_ready, 0);
        sig_in[2] = 1'b1;
        @(posedge clk); #1;
        chk("wait_sig_release", cmd_ready, 1);
        chk("wait_sig_error", error, 0);

        // WAIT_FLAG sel=4 arg=1 with flag never set: timeout after TMO cycles
        do_reset();
        cmd_valid = 1'b1; cmd_op = 3'd6; cmd_sel = 5'd4; cmd_arg = 8'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (TMO - 1) @(posedge clk);
        #1;
        chk("timeout_not_yet_err", error, 0);
        chk("timeout_not_yet_rdy", cmd_ready, 0);
        @(posedge clk); #1;
        chk("timeout_error", error, 1);
        chk("timeout_idle", cmd_ready, 1);
        @(posedge clk); #1;
        chk("error_sticky", error, 1);

        // Longest delay: all-ones argument must not wrap
        do_reset();
        run_cmd(3'd3, 5'd0, 8'hff, '0, '0, 0, 8'd0, 0, 255);

        // Reset in the middle of DELAY 100 with non-zero state
        do_reset();
        run_cmd(3'd1, 5'd1, 8'd1, 32'h2, '0, 0, 8'd0, 0, 0);
        run_cmd(3'd4, 5'd2, 8'd0, 32'h2, 16'h4, 0, 8'd0, 0, 0);
        run_cmd(3'd7, 5'd0, 8'd5, 32'h2, 16'h4, 1, 8'd5, 0, 0);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_sel = 5'd0; cmd_arg = 8'd100;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ready", cmd_ready, 0);
        chk("midrst_sig_out", sig_out, 0);
        chk("midrst_flags", flags, 0);
        chk("midrst_done", vector_done, 0);
        chk("midrst_vid", vector_id, 0);
        chk("midrst_error", error, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_sel = 5'd0; cmd_arg = 8'd1;
        #1;
        chk("release_ready_low", cmd_ready, 0);
        @(posedge clk); #1;
        chk("release_ready_high", cmd_ready, 1);
        chk("release_not_taken", sig_out, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("release_cmd_taken", sig_out, 32'h1);

        // Random commands against the reference model
        do_reset();
        for (int i = 0; i < 80; i++) begin
            op  = 3'($urandom_range(0, 7));
            sel = 5'($urandom_range(0, 31));
            arg = DW'($urandom);
            if (op == 3'd3) arg = arg & 8'h07;
            sig_in = $urandom;
            model(op, sel, arg, busy, done);
            run_cmd(op, sel, arg, m_sig, m_flags, done, m_vid, m_err, busy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
